// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared constants and types for the hardwired control unit.
//   - opcode values (IR[31:27])
//   - ALU operation codes driven on aluControl
//   - step-state encoding (RESET, T0..T7, HALT)
//   - ctrl_t: one bundle holding every datapath control strobe for one step
//   - small opcode classification helpers
// Optional build macro CU_MEM_WAIT_EN is consumed by control_sequencer only.
package cpu_ctrl_pkg;

  localparam int OPC_W = 5;
  localparam int ALU_W = 5;

  localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPC_W-1:0] OP_BR   = 5'b10010;
  localparam logic [OPC_W-1:0] OP_JR   = 5'b10011;
  localparam logic [OPC_W-1:0] OP_JAL  = 5'b10100;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  // The ALU decodes the register-op opcode values directly, so the
  // ALU codes coincide with those opcodes.
  localparam logic [ALU_W-1:0] ALU_ADD = 5'b00011;
  localparam logic [ALU_W-1:0] ALU_AND = 5'b00101;
  localparam logic [ALU_W-1:0] ALU_OR  = 5'b00110;

  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_T7    = 4'd8,
    ST_HALT  = 4'd9
  } state_t;

  typedef struct packed {
    logic             pc_out;
    logic             inc_pc;
    logic             zlo_out;
    logic             zlo_in;
    logic             c_out;
    logic             mdr_out;
    logic             ram_enable;
    logic             mar_in;
    logic             pc_in;
    logic             mdr_in;
    logic             ir_in;
    logic             y_in;
    logic             r15_in;
    logic             gra;
    logic             grb;
    logic             grc;
    logic             r_in;
    logic             r_out;
    logic             ba_out;
    logic             rd;
    logic             wr;
    logic             con_in;
    logic [ALU_W-1:0] alu;
    logic             run;
    logic             illegal;
  } ctrl_t;

  function automatic logic op_is_reg_alu(input logic [OPC_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic op_is_imm_alu(input logic [OPC_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  // ld, ldi and st all start by forming rb + C in Z.
  function automatic logic op_is_addr_calc(input logic [OPC_W-1:0] op);
    return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
  endfunction

  function automatic logic op_is_legal(input logic [OPC_W-1:0] op);
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI, OP_BR, OP_JR, OP_JAL,
      OP_NOP, OP_HALT: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

  // Immediate ops reuse the ALU operation of their register counterpart.
  function automatic logic [ALU_W-1:0] imm_alu_code(input logic [OPC_W-1:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cu_step_decode.sv
// cu_step_decode: purely combinational map from (step state, opcode, con)
// to the full control word for that step. Any strobe not set for a step is 0.
// Ports:
//   state_i   current step state
//   opcode_i  IR[31:27]
//   con_i     CON flip-flop output, only consulted in T6 of br
//   cw_o      control word (strobes, aluControl, run, illegal)
module cu_step_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t           state_i,
  input  logic [OPC_W-1:0] opcode_i,
  input  logic             con_i,
  output ctrl_t            cw_o
);

  logic is_reg_alu;
  logic is_imm_alu;
  logic is_addr_calc;
  logic is_legal;

  assign is_reg_alu   = op_is_reg_alu(opcode_i);
  assign is_imm_alu   = op_is_imm_alu(opcode_i);
  assign is_addr_calc = op_is_addr_calc(opcode_i);
  assign is_legal     = op_is_legal(opcode_i);

  always_comb begin
    cw_o = '0;
    case (state_i)
      ST_T0: begin
        cw_o.run    = 1'b1;
        cw_o.pc_out = 1'b1;
        cw_o.mar_in = 1'b1;
        cw_o.inc_pc = 1'b1;
      end
      ST_T1: begin
        cw_o.run        = 1'b1;
        cw_o.rd         = 1'b1;
        cw_o.ram_enable = 1'b1;
        cw_o.mdr_in     = 1'b1;
      end
      ST_T2: begin
        cw_o.run     = 1'b1;
        cw_o.mdr_out = 1'b1;
        cw_o.ir_in   = 1'b1;
      end
      ST_T3: begin
        cw_o.run = 1'b1;
        if (opcode_i == OP_JAL) begin
          cw_o.r15_in = 1'b1;
          cw_o.pc_out = 1'b1;
        end else if (opcode_i == OP_JR) begin
          cw_o.gra   = 1'b1;
          cw_o.r_out = 1'b1;
          cw_o.pc_in = 1'b1;
        end else if (is_reg_alu || is_imm_alu) begin
          cw_o.grb   = 1'b1;
          cw_o.r_out = 1'b1;
          cw_o.y_in  = 1'b1;
        end else if (is_addr_calc) begin
          // BAout drives 0 onto the bus when rb is r0.
          cw_o.grb    = 1'b1;
          cw_o.ba_out = 1'b1;
          cw_o.y_in   = 1'b1;
        end else if (opcode_i == OP_BR) begin
          cw_o.gra    = 1'b1;
          cw_o.r_out  = 1'b1;
          cw_o.con_in = 1'b1;
        end else if (!is_legal) begin
          cw_o.illegal = 1'b1;
        end
      end
      ST_T4: begin
        cw_o.run = 1'b1;
        if (opcode_i == OP_JAL) begin
          cw_o.gra   = 1'b1;
          cw_o.r_out = 1'b1;
          cw_o.pc_in = 1'b1;
        end else if (is_reg_alu) begin
          cw_o.grc    = 1'b1;
          cw_o.r_out  = 1'b1;
          cw_o.zlo_in = 1'b1;
          cw_o.alu    = opcode_i;
        end else if (is_imm_alu) begin
          cw_o.c_out  = 1'b1;
          cw_o.zlo_in = 1'b1;
          cw_o.alu    = imm_alu_code(opcode_i);
        end else if (is_addr_calc) begin
          cw_o.c_out  = 1'b1;
          cw_o.zlo_in = 1'b1;
          cw_o.alu    = ALU_ADD;
        end else if (opcode_i == OP_BR) begin
          cw_o.pc_out = 1'b1;
          cw_o.y_in   = 1'b1;
        end
      end
      ST_T5: begin
        cw_o.run = 1'b1;
        if (is_reg_alu || is_imm_alu || opcode_i == OP_LDI) begin
          cw_o.zlo_out = 1'b1;
          cw_o.gra     = 1'b1;
          cw_o.r_in    = 1'b1;
        end else if (opcode_i == OP_LD || opcode_i == OP_ST) begin
          cw_o.zlo_out = 1'b1;
          cw_o.mar_in  = 1'b1;
        end else if (opcode_i == OP_BR) begin
          cw_o.c_out  = 1'b1;
          cw_o.zlo_in = 1'b1;
          cw_o.alu    = ALU_ADD;
        end
      end
      ST_T6: begin
        cw_o.run = 1'b1;
        if (opcode_i == OP_LD) begin
          cw_o.rd         = 1'b1;
          cw_o.ram_enable = 1'b1;
          cw_o.mdr_in     = 1'b1;
        end else if (opcode_i == OP_ST) begin
          // read stays low so MDR loads from the bus, not memory.
          cw_o.gra    = 1'b1;
          cw_o.r_out  = 1'b1;
          cw_o.mdr_in = 1'b1;
        end else if (opcode_i == OP_BR && con_i) begin
          cw_o.zlo_out = 1'b1;
          cw_o.pc_in   = 1'b1;
        end
      end
      ST_T7: begin
        cw_o.run = 1'b1;
        if (opcode_i == OP_LD) begin
          cw_o.mdr_out = 1'b1;
          cw_o.gra     = 1'b1;
          cw_o.r_in    = 1'b1;
        end else if (opcode_i == OP_ST) begin
          cw_o.wr         = 1'b1;
          cw_o.ram_enable = 1'b1;
        end
      end
      default: cw_o = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the RISC datapath.
// Runs fetch (T0-T2), decodes IR[31:27] and steps through the execute
// states (T3-T7) before returning to T0. Outputs are decoded from the state
// register and ir by cu_step_decode.
// Build option: CU_MEM_WAIT_EN -- when defined, fetch T1, ld T6 and st T7
// stall until mem_ready=1; otherwise every step is one cycle and mem_ready
// is ignored.
// Ports:
//   clock, clear      rising-edge clock, synchronous active-high reset
//   ir, con           instruction register, CON flip-flop output
//   mem_ready         memory handshake (CU_MEM_WAIT_EN builds only)
//   PCout..conin      datapath strobes / load enables / select controls
//   aluControl        ALU operation code
//   run               high in T0-T7
//   illegal           one-cycle pulse in T3 for an undefined opcode
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      ir,
  input  logic             con,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             IncPC,
  output logic             ZLOout,
  output logic             ZLOin,
  output logic             Cout,
  output logic             MDRout,
  output logic             RAMenable,
  output logic             MARin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             R15in,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic             BAout,
  output logic             read,
  output logic             write,
  output logic             conin,
  output logic [ALU_W-1:0] aluControl,
  output logic             run,
  output logic             illegal
);

  state_t           state_q;
  state_t           state_d;
  logic [OPC_W-1:0] opcode;
  logic             mem_ok;
  ctrl_t            cw;

  assign opcode = ir[31:27];

  // Only the opcode field steers sequencing; register fields go to the datapath.
  logic [26:0] unused_ir_fields;
  assign unused_ir_fields = ir[26:0];

`ifdef CU_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
`endif

  always_ff @(posedge clock) begin
    if (clear) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_T0;
      ST_T0:    state_d = ST_T1;
      ST_T1:    state_d = mem_ok ? ST_T2 : ST_T1;
      ST_T2:    state_d = ST_T3;
      ST_T3: begin
        if (opcode == OP_HALT)
          state_d = ST_HALT;
        else if (opcode == OP_JR || opcode == OP_NOP || !op_is_legal(opcode))
          state_d = ST_T0;
        else
          state_d = ST_T4;
      end
      ST_T4:    state_d = (opcode == OP_JAL) ? ST_T0 : ST_T5;
      ST_T5: begin
        if (opcode == OP_LD || opcode == OP_ST || opcode == OP_BR)
          state_d = ST_T6;
        else
          state_d = ST_T0;
      end
      ST_T6: begin
        if (opcode == OP_LD)
          state_d = mem_ok ? ST_T7 : ST_T6;
        else if (opcode == OP_ST)
          state_d = ST_T7;
        else
          state_d = ST_T0;
      end
      ST_T7: begin
        if (opcode == OP_ST)
          state_d = mem_ok ? ST_T0 : ST_T7;
        else
          state_d = ST_T0;
      end
      ST_HALT:  state_d = ST_HALT;
      // Unused encodings recover through RESET.
      default:  state_d = ST_RESET;
    endcase
  end

  cu_step_decode u_step_decode (
    .state_i  (state_q),
    .opcode_i (opcode),
    .con_i    (con),
    .cw_o     (cw)
  );

  always_comb begin
    PCout      = cw.pc_out;
    IncPC      = cw.inc_pc;
    ZLOout     = cw.zlo_out;
    ZLOin      = cw.zlo_in;
    Cout       = cw.c_out;
    MDRout     = cw.mdr_out;
    RAMenable  = cw.ram_enable;
    MARin      = cw.mar_in;
    PCin       = cw.pc_in;
    MDRin      = cw.mdr_in;
    IRin       = cw.ir_in;
    Yin        = cw.y_in;
    R15in      = cw.r15_in;
    Gra        = cw.gra;
    Grb        = cw.grb;
    Grc        = cw.grc;
    Rin        = cw.r_in;
    Rout       = cw.r_out;
    BAout      = cw.ba_out;
    read       = cw.rd;
    write      = cw.wr;
    conin      = cw.con_in;
    aluControl = cw.alu;
    run        = cw.run;
    illegal    = cw.illegal;
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] ir;
  logic        con;
  logic        mem_ready;
  logic PCout, IncPC, ZLOout, ZLOin, Cout, MDRout, RAMenable;
  logic MARin, PCin, MDRin, IRin, Yin, R15in;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic read, write, conin;
  logic [4:0] aluControl;
  logic run, illegal;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .con(con), .mem_ready(mem_ready),
    .PCout(PCout), .IncPC(IncPC), .ZLOout(ZLOout), .ZLOin(ZLOin), .Cout(Cout),
    .MDRout(MDRout), .RAMenable(RAMenable), .MARin(MARin), .PCin(PCin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .R15in(R15in), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .read(read), .write(write),
    .conin(conin), .aluControl(aluControl), .run(run), .illegal(illegal)
  );

  always #5 clock = ~clock;

  localparam int NB = 22;
  logic [NB-1:0] obs;
  assign obs = {conin, write, read, BAout, Rout, Rin, Grc, Grb, Gra, R15in, Yin,
                IRin, MDRin, PCin, MARin, RAMenable, MDRout, Cout, ZLOin, ZLOout,
                IncPC, PCout};

  localparam logic [NB-1:0] M_PCOUT  = 22'd1 << 0;
  localparam logic [NB-1:0] M_INCPC  = 22'd1 << 1;
  localparam logic [NB-1:0] M_ZLOOUT = 22'd1 << 2;
  localparam logic [NB-1:0] M_ZLOIN  = 22'd1 << 3;
  localparam logic [NB-1:0] M_COUT   = 22'd1 << 4;
  localparam logic [NB-1:0] M_MDROUT = 22'd1 << 5;
  localparam logic [NB-1:0] M_RAM    = 22'd1 << 6;
  localparam logic [NB-1:0] M_MARIN  = 22'd1 << 7;
  localparam logic [NB-1:0] M_PCIN   = 22'd1 << 8;
  localparam logic [NB-1:0] M_MDRIN  = 22'd1 << 9;
  localparam logic [NB-1:0] M_IRIN   = 22'd1 << 10;
  localparam logic [NB-1:0] M_YIN    = 22'd1 << 11;
  localparam logic [NB-1:0] M_R15IN  = 22'd1 << 12;
  localparam logic [NB-1:0] M_GRA    = 22'd1 << 13;
  localparam logic [NB-1:0] M_GRB    = 22'd1 << 14;
  localparam logic [NB-1:0] M_GRC    = 22'd1 << 15;
  localparam logic [NB-1:0] M_RIN    = 22'd1 << 16;
  localparam logic [NB-1:0] M_ROUT   = 22'd1 << 17;
  localparam logic [NB-1:0] M_BAOUT  = 22'd1 << 18;
  localparam logic [NB-1:0] M_READ   = 22'd1 << 19;
  localparam logic [NB-1:0] M_WRITE  = 22'd1 << 20;
  localparam logic [NB-1:0] M_CONIN  = 22'd1 << 21;

  localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010;
  localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, AND_ = 5'b00101, OR_ = 5'b00110;
  localparam logic [4:0] ADDI = 5'b01100, ANDI = 5'b01101, ORI = 5'b01110;
  localparam logic [4:0] BR = 5'b10010, JR = 5'b10011, JAL = 5'b10100;
  localparam logic [4:0] NOP = 5'b11010, HALT = 5'b11011;

  typedef struct {
    logic [NB-1:0] sig;
    logic [4:0]    alu;
    logic          ill;
  } step_t;

  step_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [NB-1:0] s, input logic [4:0] a, input logic ill);
    step_t st;
    st.sig = s;
    st.alu = a;
    st.ill = ill;
    exp_q.push_back(st);
  endtask

  // Per-cycle strobe sets of one instruction, T0 through its last step.
  task automatic build_expect(input logic [4:0] opc, input logic c);
    exp_q.delete();
    push(M_PCOUT | M_MARIN | M_INCPC, 5'd0, 1'b0);
    push(M_READ | M_RAM | M_MDRIN, 5'd0, 1'b0);
    push(M_MDROUT | M_IRIN, 5'd0, 1'b0);
    case (opc)
      JAL: begin
        push(M_R15IN | M_PCOUT, 5'd0, 1'b0);
        push(M_GRA | M_ROUT | M_PCIN, 5'd0, 1'b0);
      end
      JR: push(M_GRA | M_ROUT | M_PCIN, 5'd0, 1'b0);
      ADD, SUB, AND_, OR_, ADDI, ANDI, ORI: begin
        logic [4:0] a;
        a = (opc == ADDI) ? ADD : (opc == ANDI) ? AND_ : (opc == ORI) ? OR_ : opc;
        push(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b0);
        if (opc == a) push(M_GRC | M_ROUT | M_ZLOIN, a, 1'b0);
        else          push(M_COUT | M_ZLOIN, a, 1'b0);
        push(M_ZLOOUT | M_GRA | M_RIN, 5'd0, 1'b0);
      end
      LDI, LD, ST: begin
        push(M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b0);
        push(M_COUT | M_ZLOIN, ADD, 1'b0);
        if (opc == LDI) begin
          push(M_ZLOOUT | M_GRA | M_RIN, 5'd0, 1'b0);
        end else begin
          push(M_ZLOOUT | M_MARIN, 5'd0, 1'b0);
          if (opc == LD) begin
            push(M_READ | M_RAM | M_MDRIN, 5'd0, 1'b0);
            push(M_MDROUT | M_GRA | M_RIN, 5'd0, 1'b0);
          end else begin
            push(M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'b0);
            push(M_WRITE | M_RAM, 5'd0, 1'b0);
          end
        end
      end
      BR: begin
        push(M_GRA | M_ROUT | M_CONIN, 5'd0, 1'b0);
        push(M_PCOUT | M_YIN, 5'd0, 1'b0);
        push(M_COUT | M_ZLOIN, ADD, 1'b0);
        push(c ? (M_ZLOOUT | M_PCIN) : '0, 5'd0, 1'b0);
      end
      NOP, HALT: push('0, 5'd0, 1'b0);
      default:   push('0, 5'd0, 1'b1);
    endcase
  endtask

  task automatic check_now(input string tag, input logic [NB-1:0] s, input logic [4:0] a,
                           input logic r, input logic ill);
    chk_eq({tag, " sig"}, 32'(obs), 32'(s));
    chk_eq({tag, " alu/run/ill"}, {25'd0, aluControl, run, illegal}, {25'd0, a, r, ill});
  endtask

  // Entered at a falling edge with the DUT in T0; leaves at the falling edge after the last step.
  task automatic run_ir(input logic [31:0] ir_v, input logic c);
    ir  = ir_v;
    con = c;
    build_expect(ir_v[31:27], c);
    for (int k = 0; k < exp_q.size(); k++) begin
      check_now($sformatf("op%b c%0d T%0d", ir_v[31:27], c, k), exp_q[k].sig,
                exp_q[k].alu, 1'b1, exp_q[k].ill);
      @(negedge clock);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0] opc;
    clear     = 1'b1;
    ir        = 32'h0;
    con       = 1'b0;
    mem_ready = 1'b1;

    @(negedge clock);
    check_now("clear1", '0, 5'd0, 1'b0, 1'b0);
    @(negedge clock);
    check_now("clear2", '0, 5'd0, 1'b0, 1'b0);
    clear = 1'b0;
    @(negedge clock);

    run_ir(32'hA0800000, 1'b0);
    run_ir(32'h18000000, 1'b0);
    run_ir(32'h90000000, 1'b0);
    run_ir(32'h90000000, 1'b1);
    run_ir(32'hF8000000, 1'b0);

    for (int o = 0; o < 32; o++) begin
      opc = 5'(o);
      if (opc != HALT) run_ir({opc, 27'($urandom)}, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 80; i++) begin
      opc = 5'($urandom_range(0, 31));
      if (opc == HALT) opc = NOP;
      run_ir({opc, 27'($urandom)}, 1'($urandom_range(0, 1)));
    end

    // clear aborts an instruction mid-sequence
    ir = {LD, 27'($urandom)};
    repeat (5) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    check_now("abort reset", '0, 5'd0, 1'b0, 1'b0);
    clear = 1'b0;
    @(negedge clock);
    run_ir({ST, 27'($urandom)}, 1'b0);

    // halt holds until clear
    run_ir(32'hD8000000, 1'b0);
    for (int k = 0; k < 20; k++) begin
      check_now($sformatf("halt %0d", k), '0, 5'd0, 1'b0, 1'b0);
      @(negedge clock);
    end
    clear = 1'b1;
    @(negedge clock);
    check_now("halt reset", '0, 5'd0, 1'b0, 1'b0);
    clear = 1'b0;
    @(negedge clock);
    run_ir({NOP, 27'd0}, 1'b0);

`ifdef CU_MEM_WAIT_EN
    ir = {NOP, 27'd0};
    check_now("wait T0", M_PCOUT | M_MARIN | M_INCPC, 5'd0, 1'b1, 1'b0);
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      check_now($sformatf("wait T1 %0d", k), M_READ | M_RAM | M_MDRIN, 5'd0, 1'b1, 1'b0);
      mem_ready = (k == 3);
      @(negedge clock);
    end
    check_now("wait T2", M_MDROUT | M_IRIN, 5'd0, 1'b1, 1'b0);
    @(negedge clock);
    check_now("wait T3", '0, 5'd0, 1'b1, 1'b0);
    @(negedge clock);
`endif

    check_now("final T0", M_PCOUT | M_MARIN | M_INCPC, 5'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
